// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage feeding a combinational ALU: register file with EX bypass,
// one EX pipeline register, registered writeback port and a retired-instruction counter.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [$clog2(NREGS)-1:0] in_rs1,
    input  logic [$clog2(NREGS)-1:0] in_rs2,
    input  logic                     in_use_imm,
    input  logic [WIDTH-1:0]         in_imm,
    input  logic                     hold,
    input  logic                     flush,
    output logic [2:0]               alu_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_y,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_rd,
    output logic [WIDTH-1:0]         wb_data,
    output logic [CNTW-1:0]          retire_cnt,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic             ex_valid;
    logic [AW-1:0]    ex_rd;
    logic             accept;
    logic             retire;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign in_ready = !hold && !flush;
    assign accept   = in_valid && in_ready;
    assign retire   = ex_valid && !hold && !flush;

    // The instruction in EX writes back on the same edge the reader latches,
    // so forwarding alu_y removes any need to stall.
    always_comb begin
        op_a = '0;
        if (in_rs1 != '0) begin
            if (ex_valid && (ex_rd == in_rs1)) begin
                op_a = alu_y;
            end else begin
                op_a = regs[in_rs1];
            end
        end
    end

    always_comb begin
        op_b = '0;
        if (in_use_imm) begin
            op_b = in_imm;
        end else if (in_rs2 != '0) begin
            if (ex_valid && (ex_rd == in_rs2)) begin
                op_b = alu_y;
            end else begin
                op_b = regs[in_rs2];
            end
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_rd    <= '0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!hold) begin
            ex_valid <= accept;
            if (accept) begin
                ex_rd  <= in_rd;
                alu_op <= in_op;
                alu_a  <= op_a;
                alu_b  <= op_b;
            end
        end
    end

    // Writeback: rd 0 is still reported on the wb port but never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (retire && (ex_rd != '0)) begin
            regs[ex_rd] <= alu_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            retire_cnt <= '0;
        end else if (retire) begin
            wb_valid   <= 1'b1;
            wb_rd      <= ex_rd;
            wb_data    <= alu_y;
            retire_cnt <= retire_cnt + CNTW'(1);
        end else begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with a behavioural ALU model closing the loop.
module tb_alu_issue_stage;

    localparam int WIDTH = 32;
    localparam int NREGS = 8;
    localparam int CNTW  = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [2:0]       in_rd;
    logic [2:0]       in_rs1;
    logic [2:0]       in_rs2;
    logic             in_use_imm;
    logic [WIDTH-1:0] in_imm;
    logic             hold;
    logic             flush;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             wb_valid;
    logic [2:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic [CNTW-1:0]  retire_cnt;
    logic [2:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    int passed;
    int total;
    logic [CNTW-1:0] exp_cnt;

    alu_issue_stage #(.WIDTH(WIDTH), .NREGS(NREGS), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .hold       (hold),
        .flush      (flush),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .retire_cnt (retire_cnt),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Downstream ALU model; SLT is unsigned.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_y = alu_a + alu_b;
            OP_SUB:  alu_y = alu_a - alu_b;
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            default: alu_y = '0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic use_imm, input logic [WIDTH-1:0] imm);
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = use_imm;
        in_imm     = imm;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_use_imm = 1'b0;
        in_imm     = '0;
    endtask

    task automatic bump_cnt();
        exp_cnt = exp_cnt + CNTW'(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        if ({alu_op, alu_a, alu_b, wb_valid, wb_rd, wb_data, retire_cnt} !== '0) begin
            $display("[TB] FAIL reset_outputs got nonzero outputs wb_data=%h alu_a=%h cnt=%0d exp all 0",
                     wb_data, alu_a, retire_cnt);
        end else passed++;
        total++;
        step();
        rst_n = 1'b1;
        #1;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b exp 1", in_ready);
        else passed++;
        total++;
        step();

        issue(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 32'h55);
        step();
        issue(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 32'h33);
        step();
        if (wb_valid !== 1'b1 || wb_data !== 32'h55 || retire_cnt !== 4'd1 || alu_b !== 32'h33)
            $display("[TB] FAIL pre_reset_retire got v=%b data=%h cnt=%0d alu_b=%h exp 1/55/1/33",
                     wb_valid, wb_data, retire_cnt, alu_b);
        else passed++;
        total++;

        idle();
        #3;
        rst_n = 1'b0;
        #1;
        if ({alu_op, alu_a, alu_b, wb_valid, wb_rd, wb_data, retire_cnt} !== '0) begin
            $display("[TB] FAIL async_reset_outputs got wb_data=%h alu_b=%h cnt=%0d exp all 0",
                     wb_data, alu_b, retire_cnt);
        end else passed++;
        total++;
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = 3'(i);
            #1;
            if (dbg_data !== '0) $display("[TB] FAIL reset_dbg_r%0d got %h exp 0", i, dbg_data);
            else passed++;
            total++;
        end
        rst_n = 1'b1;
        step();
        step();
        dbg_addr = 3'd6;
        #1;
        if (wb_valid !== 1'b0 || retire_cnt !== 4'd0 || dbg_data !== '0 || in_ready !== 1'b1)
            $display("[TB] FAIL reset_discard got v=%b cnt=%0d r6=%h rdy=%b exp 0/0/0/1",
                     wb_valid, retire_cnt, dbg_data, in_ready);
        else passed++;
        total++;
        exp_cnt = '0;
    endtask

    task automatic test_back_to_back();
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
        step();
        issue(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 32'h0);
        step();
        bump_cnt();
        if (wb_valid !== 1'b1 || wb_rd !== 3'd1 || wb_data !== 32'd5)
            $display("[TB] FAIL b2b_first got v=%b rd=%0d data=%h exp 1/1/5", wb_valid, wb_rd, wb_data);
        else passed++;
        total++;
        if (alu_a !== 32'd5 || alu_b !== 32'd5)
            $display("[TB] FAIL b2b_bypass got a=%h b=%h exp 5/5", alu_a, alu_b);
        else passed++;
        total++;
        idle();
        step();
        bump_cnt();
        if (wb_valid !== 1'b1 || wb_rd !== 3'd2 || wb_data !== 32'd10)
            $display("[TB] FAIL b2b_second got v=%b rd=%0d data=%h exp 1/2/a", wb_valid, wb_rd, wb_data);
        else passed++;
        total++;
        step();
        dbg_addr = 3'd2;
        #1;
        if (wb_valid !== 1'b0 || dbg_data !== 32'd10 || retire_cnt !== 4'd2)
            $display("[TB] FAIL b2b_state got v=%b r2=%h cnt=%0d exp 0/a/2", wb_valid, dbg_data, retire_cnt);
        else passed++;
        total++;
    endtask

    task automatic test_wrap_compare();
        issue(OP_SUB, 3'd3, 3'd0, 3'd0, 1'b1, 32'd1);
        step();
        issue(OP_SLT, 3'd4, 3'd0, 3'd3, 1'b0, 32'h0);
        step();
        bump_cnt();
        if (wb_rd !== 3'd3 || wb_data !== 32'hFFFF_FFFF)
            $display("[TB] FAIL sub_wrap got rd=%0d data=%h exp 3/ffffffff", wb_rd, wb_data);
        else passed++;
        total++;
        issue(OP_SLT, 3'd5, 3'd3, 3'd0, 1'b0, 32'h0);
        step();
        bump_cnt();
        if (wb_rd !== 3'd4 || wb_data !== 32'd1)
            $display("[TB] FAIL slt_lt got rd=%0d data=%h exp 4/1", wb_rd, wb_data);
        else passed++;
        total++;
        idle();
        step();
        bump_cnt();
        if (wb_valid !== 1'b1 || wb_rd !== 3'd5 || wb_data !== 32'd0)
            $display("[TB] FAIL slt_ge got v=%b rd=%0d data=%h exp 1/5/0", wb_valid, wb_rd, wb_data);
        else passed++;
        total++;
        if (retire_cnt !== exp_cnt)
            $display("[TB] FAIL wrap_cnt got %0d exp %0d", retire_cnt, exp_cnt);
        else passed++;
        total++;
        step();
    endtask

    task automatic test_zero_reg();
        issue(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 32'd7);
        step();
        issue(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b0, 32'h0);
        step();
        bump_cnt();
        if (wb_valid !== 1'b1 || wb_rd !== 3'd0 || wb_data !== 32'd7)
            $display("[TB] FAIL zero_wb got v=%b rd=%0d data=%h exp 1/0/7", wb_valid, wb_rd, wb_data);
        else passed++;
        total++;
        if (alu_a !== '0 || alu_b !== '0)
            $display("[TB] FAIL zero_nobypass got a=%h b=%h exp 0/0", alu_a, alu_b);
        else passed++;
        total++;
        idle();
        step();
        bump_cnt();
        dbg_addr = 3'd0;
        #1;
        if (wb_rd !== 3'd6 || wb_data !== '0 || dbg_data !== '0)
            $display("[TB] FAIL zero_read got rd=%0d data=%h r0=%h exp 6/0/0", wb_rd, wb_data, dbg_data);
        else passed++;
        total++;
    endtask

    task automatic test_hold_flush();
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd9);
        step();
        issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'h77);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (in_ready !== 1'b0) $display("[TB] FAIL hold_ready got %b exp 0", in_ready);
            else passed++;
            total++;
            step();
            if (wb_valid !== 1'b0 || alu_a !== '0 || alu_b !== 32'd9 || alu_op !== OP_ADD)
                $display("[TB] FAIL hold_stable got v=%b a=%h b=%h op=%0d exp 0/0/9/0",
                         wb_valid, alu_a, alu_b, alu_op);
            else passed++;
            total++;
        end
        hold = 1'b0;
        idle();
        step();
        bump_cnt();
        if (wb_valid !== 1'b1 || wb_rd !== 3'd1 || wb_data !== 32'd9)
            $display("[TB] FAIL hold_release got v=%b rd=%0d data=%h exp 1/1/9", wb_valid, wb_rd, wb_data);
        else passed++;
        total++;
        step();
        dbg_addr = 3'd2;
        #1;
        if (wb_valid !== 1'b0 || dbg_data !== 32'd10)
            $display("[TB] FAIL hold_no_accept got v=%b r2=%h exp 0/a", wb_valid, dbg_data);
        else passed++;
        total++;

        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h42);
        step();
        idle();
        hold  = 1'b1;
        flush = 1'b1;
        #1;
        if (in_ready !== 1'b0) $display("[TB] FAIL flush_ready got %b exp 0", in_ready);
        else passed++;
        total++;
        step();
        hold  = 1'b0;
        flush = 1'b0;
        step();
        step();
        dbg_addr = 3'd1;
        #1;
        if (wb_valid !== 1'b0 || dbg_data !== 32'd9 || retire_cnt !== exp_cnt)
            $display("[TB] FAIL flush_drop got v=%b r1=%h cnt=%0d exp 0/9/%0d",
                     wb_valid, dbg_data, retire_cnt, exp_cnt);
        else passed++;
        total++;
    endtask

    task automatic test_counter_wrap();
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            issue(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 32'd1);
            step();
        end
        idle();
        step();
        dbg_addr = 3'd1;
        #1;
        if (retire_cnt !== 4'd1)
            $display("[TB] FAIL cnt_wrap got %0d exp 1", retire_cnt);
        else passed++;
        total++;
        if (wb_data !== 32'd17 || dbg_data !== 32'd17)
            $display("[TB] FAIL chain_bypass got wb=%h r1=%h exp 11/11", wb_data, dbg_data);
        else passed++;
        total++;
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        exp_cnt    = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_use_imm = 1'b0;
        in_imm     = '0;
        hold       = 1'b0;
        flush      = 1'b0;
        dbg_addr   = '0;
        test_reset();
        test_back_to_back();
        test_wrap_compare();
        test_zero_reg();
        test_hold_flush();
        test_counter_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
